seq_101x_frame_tx: RTL and testbench

SEQ_101X_FRAME_TX -- requirements
Module: seq_101x_frame_tx

---
 rtl/seq_fsm_pkg.sv | 15 +
 rtl/seq_tx_shreg.sv | 52 +++++
 rtl/seq_101x_frame_tx.sv | 81 ++++++++
 tb/tb_seq_101x_frame_tx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seq_fsm_pkg.sv
// Shared FSM encodings and the frame sync pattern for the serial frame transmitter.
package seq_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC1 = 3'd1,
    SYNC0 = 3'd2,
    SYNC2 = 3'd3,
    DATA  = 3'd4
  } state_t;

  // Sent MSB first: SYNC1, SYNC0, SYNC2.
  localparam logic [2:0] SYNC_PAT = 3'b101;

endpackage

// File: rtl/seq_tx_shreg.sv
// Payload shift register and bit counter for seq_101x_frame_tx.
module seq_tx_shreg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              shift,
  input  logic              clr,
  output logic              last,
  output logic              first_bit,
  output logic              next_bit
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0] sh;
  logic [CNT_W-1:0]  cnt;

  // A load in the final DATA cycle wins over the shift so back-to-back frames start cleanly.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sh <= '0;
    end else if (load) begin
      sh <= data;
    end else if (shift) begin
      sh <= sh << 1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (shift) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last      = (cnt == CNT_W'(DATA_W - 1));
  assign first_bit = sh[DATA_W-1];

  // MSB after this cycle's shift; never used when DATA_W=1 since DATA lasts one cycle.
  if (DATA_W > 1) begin : g_next_wide
    assign next_bit = sh[DATA_W-2];
  end else begin : g_next_single
    assign next_bit = 1'b0;
  end

endmodule

// File: rtl/seq_101x_frame_tx.sv
// Serial frame transmitter: sync pattern 1,0,1 then DATA_W payload bits MSB first.
module seq_101x_frame_tx
  import seq_fsm_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Load,
  input  logic [DATA_W-1:0] Data,
  output logic              Ready,
  output logic              OP,
  output logic              Done,
  output logic [2:0]        CS,
  output logic [2:0]        NS
);

  state_t cs, ns;
  logic   op_d;
  logic   accept, last, first_bit, next_bit, enter_data;

  seq_tx_shreg #(.DATA_W(DATA_W)) u_shreg (
    .Clk       (Clk),
    .Rst       (Rst),
    .load      (accept),
    .data      (Data),
    .shift     (cs == DATA),
    .clr       (enter_data),
    .last      (last),
    .first_bit (first_bit),
    .next_bit  (next_bit)
  );

  assign Done       = (cs == DATA) && last;
  assign Ready      = (cs == IDLE) || Done;
  assign accept     = Load && Ready;
  assign enter_data = (ns == DATA) && (cs != DATA);
  assign CS         = cs;
  assign NS         = ns;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cs <= IDLE;
    end else begin
      cs <= ns;
    end
  end

  always_comb begin
    ns = IDLE;
    case (cs)
      IDLE:    ns = Load ? SYNC1 : IDLE;
      SYNC1:   ns = SYNC0;
      SYNC0:   ns = SYNC2;
      SYNC2:   ns = DATA;
      DATA:    ns = last ? (Load ? SYNC1 : IDLE) : DATA;
      default: ns = IDLE;
    endcase
  end

  // OP is registered from the next state so it lines up with the state it belongs to.
  always_comb begin
    op_d = 1'b0;
    case (ns)
      SYNC1:   op_d = SYNC_PAT[2];
      SYNC0:   op_d = SYNC_PAT[1];
      SYNC2:   op_d = SYNC_PAT[0];
      DATA:    op_d = (cs == DATA) ? next_bit : first_bit;
      default: op_d = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      OP <= 1'b0;
    end else begin
      OP <= op_d;
    end
  end

endmodule

// File: tb/tb_seq_101x_frame_tx.sv
// Scoreboard bench for seq_101x_frame_tx with DATA_W=8 and DATA_W=1 instances.
module tb_seq_101x_frame_tx;

  typedef struct packed {
    logic op;
    logic done;
  } exp_t;

  logic       clk;
  logic       rst8, load8, ready8, op8, done8;
  logic [7:0] data8;
  logic [2:0] cs8, ns8;
  logic       rst1, load1, ready1, op1, done1;
  logic [0:0] data1;
  logic [2:0] cs1, ns1;

  exp_t q8[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  seq_101x_frame_tx #(.DATA_W(8)) dut8 (
    .Clk(clk), .Rst(rst8), .Load(load8), .Data(data8), .Ready(ready8),
    .OP(op8), .Done(done8), .CS(cs8), .NS(ns8)
  );

  seq_101x_frame_tx #(.DATA_W(1)) dut1 (
    .Clk(clk), .Rst(rst1), .Load(load1), .Data(data1), .Ready(ready1),
    .OP(op1), .Done(done1), .CS(cs1), .NS(ns1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected OP/Done for the first n cycles of an 8-bit frame.
  task automatic push8(input logic [7:0] d, input int n);
    exp_t e;
    logic [10:0] bits;
    bits = {3'b101, d};
    for (int i = 0; i < 11 && i < n; i++) begin
      e.op   = bits[10-i];
      e.done = (i == 10);
      q8.push_back(e);
    end
  endtask

  task automatic push1(input logic d);
    exp_t e;
    logic [3:0] bits;
    bits = {3'b101, d};
    for (int i = 0; i < 4; i++) begin
      e.op   = bits[3-i];
      e.done = (i == 3);
      q1.push_back(e);
    end
  endtask

  always @(negedge clk) begin : mon8
    exp_t e;
    if (cs8 != 3'd0) begin
      if (q8.size() == 0) check("dut8 unexpected frame cycle", 1, 0);
      else begin
        e = q8.pop_front();
        check("dut8 OP", op8, e.op);
        check("dut8 Done", done8, e.done);
      end
    end else begin
      check("dut8 idle OP", op8, 0);
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (cs1 != 3'd0) begin
      if (q1.size() == 0) check("dut1 unexpected frame cycle", 1, 0);
      else begin
        e = q1.pop_front();
        check("dut1 OP", op1, e.op);
        check("dut1 Done", done1, e.done);
      end
    end else begin
      check("dut1 idle OP", op1, 0);
    end
  end

  initial begin
    rst8 = 1'b0; load8 = 1'b0; data8 = 8'h00;
    rst1 = 1'b0; load1 = 1'b0; data1 = 1'b0;
    tick(2);
    check("reset CS", cs8, 0);
    check("reset OP", op8, 0);
    check("reset Done", done8, 0);
    check("reset Ready", ready8, 1);

    // First accept on the first edge after reset release; A5 frame.
    rst8 = 1'b1; rst1 = 1'b1;
    load8 = 1'b1; data8 = 8'hA5; push8(8'hA5, 11);
    tick(1);
    load8 = 1'b0;
    tick(10);
    check("A5 last cycle Done", done8, 1);
    check("A5 last cycle Ready", ready8, 1);
    tick(1);
    check("A5 after Ready", ready8, 1);
    check("A5 after CS", cs8, 0);
    check("A5 after Done", done8, 0);

    // Back-to-back FF then 00 with Load held high.
    load8 = 1'b1; data8 = 8'hFF; push8(8'hFF, 11); push8(8'h00, 11);
    tick(1);
    data8 = 8'h00;
    check("FF sync1 Ready", ready8, 0);
    tick(11);
    load8 = 1'b0;
    tick(11);
    check("FF/00 back to idle", cs8, 0);

    // Load with 3C during SYNC0 is ignored.
    load8 = 1'b1; data8 = 8'hA5; push8(8'hA5, 11);
    tick(1);
    load8 = 1'b0;
    tick(1);
    load8 = 1'b1; data8 = 8'h3C;
    check("SYNC0 CS", cs8, 2);
    check("SYNC0 NS", ns8, 3);
    tick(1);
    load8 = 1'b0;
    tick(9);
    check("ignored load back to idle", cs8, 0);

    // Reset in the 6th cycle of a frame.
    load8 = 1'b1; data8 = 8'hA5; push8(8'hA5, 5);
    tick(1);
    load8 = 1'b0;
    tick(5);
    #2 rst8 = 1'b0;
    #1;
    check("async reset OP", op8, 0);
    check("async reset CS", cs8, 0);
    check("async reset Done", done8, 0);
    load8 = 1'b1; data8 = 8'h3C;
    tick(2);
    check("load ignored in reset", cs8, 0);
    rst8 = 1'b1; data8 = 8'h81; push8(8'h81, 11);
    tick(1);
    load8 = 1'b0;
    tick(11);
    check("81 back to idle", cs8, 0);

    // DATA_W=1: three back-to-back frames.
    load1 = 1'b1; data1 = 1'b1;
    push1(1'b1); push1(1'b1); push1(1'b1);
    tick(1);
    tick(3);
    check("W1 DATA Done", done1, 1);
    check("W1 DATA Ready", ready1, 1);
    tick(5);
    load1 = 1'b0;
    tick(4);
    check("W1 back to idle", cs1, 0);

    check("dut8 scoreboard drained", q8.size(), 0);
    check("dut1 scoreboard drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
